// File: rtl/dmem_pkg.sv
// Shared size encodings and lane/alignment helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Load context captured at the sample edge and consumed by the output steering.
  typedef struct packed {
    logic       valid;
    logic       mis;
    logic [1:0] size;
    logic [1:0] lo;
  } ld_ctx_t;

  // Reserved size 2'b11 falls through to word handling everywhere.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: lane_mask = 4'b0001 << lo;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: is_misaligned = lo[0];
      SZ_BYTE: is_misaligned = 1'b0;
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_HALF: store_data = {2{wdata[15:0]}};
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_steer(input logic [1:0] size, input logic [1:0] lo,
                                             input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lo, 3'b000};
    case (size)
      SZ_HALF: load_steer = {16'h0000, shifted[15:0]};
      SZ_BYTE: load_steer = {24'h000000, shifted[7:0]};
      default: load_steer = shifted;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        MRE;
  logic [31:0] RADDR;
  logic [1:0]  RWHBS;
  logic        WE;
  logic [31:0] WADDR;
  logic [31:0] WData;
  logic [1:0]  WWHBS;
  logic        FaultClr;
  logic [31:0] RAMData;
  logic        Fault;
  logic [31:0] FaultAddr;

  modport master (
    output MRE, RADDR, RWHBS, WE, WADDR, WData, WWHBS, FaultClr,
    input  RAMData, Fault, FaultAddr
  );

  modport slave (
    input  MRE, RADDR, RWHBS, WE, WADDR, WData, WWHBS, FaultClr,
    output RAMData, Fault, FaultAddr
  );
endinterface

// File: rtl/dmem_byte_bank.sv
// One byte lane of data memory: synchronous write with enable, synchronous read-first read.
module dmem_byte_bank #(
  parameter int unsigned AW = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];
  logic [7:0] rdata_q;

  // Contents are deliberately not reset so the array maps onto SRAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane steering, collision handling and misalignment fault capture.
// Define DMEM_BYPASS_EN for write-first same-word load/store; otherwise loads are read-first.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input logic               CLK,
  input logic               rst_n,
  dmem_responder_if.slave   bus
);

  logic [AW-1:0] ridx, widx;
  logic          rd_mis_raw, rd_mis, wr_mis, st_fire;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic [31:0]   bank_rdata;
  logic [31:0]   merged_word;

  assign ridx       = bus.RADDR[AW+1:2];
  assign widx       = bus.WADDR[AW+1:2];
  assign rd_mis_raw = is_misaligned(bus.RWHBS, bus.RADDR[1:0]);
  assign rd_mis     = bus.MRE & rd_mis_raw;
  assign wr_mis     = bus.WE & is_misaligned(bus.WWHBS, bus.WADDR[1:0]);
  assign st_fire    = bus.WE & ~wr_mis;
  assign st_mask    = lane_mask(bus.WWHBS, bus.WADDR[1:0]);
  assign st_data    = store_data(bus.WWHBS, bus.WData);

  for (genvar i = 0; i < 4; i++) begin : g_bank
    dmem_byte_bank #(
      .AW (AW)
    ) u_bank (
      .clk_i   (CLK),
      .we_i    (st_fire & st_mask[i]),
      .waddr_i (widx),
      .wdata_i (st_data[8*i +: 8]),
      .re_i    (bus.MRE),
      .raddr_i (ridx),
      .rdata_o (bank_rdata[8*i +: 8])
    );
  end

  // Load context only advances on a sampled load, so RAMData holds while MRE is low.
  ld_ctx_t ld_q, ld_d;

  always_comb begin
    ld_d = ld_q;
    if (bus.MRE) begin
      ld_d.valid = 1'b1;
      ld_d.mis   = rd_mis_raw;
      ld_d.size  = bus.RWHBS;
      ld_d.lo    = bus.RADDR[1:0];
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) ld_q <= '0;
    else        ld_q <= ld_d;
  end

`ifdef DMEM_BYPASS_EN
  logic [3:0]  byp_mask_q, byp_mask_d;
  logic [31:0] byp_data_q, byp_data_d;

  always_comb begin
    byp_mask_d = byp_mask_q;
    byp_data_d = byp_data_q;
    if (bus.MRE) begin
      byp_mask_d = (st_fire && (widx == ridx)) ? st_mask : 4'b0000;
      byp_data_d = st_data;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      byp_mask_q <= 4'b0000;
      byp_data_q <= '0;
    end else begin
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
    end
  end

  always_comb begin
    merged_word = bank_rdata;
    for (int i = 0; i < 4; i++) begin
      if (byp_mask_q[i]) merged_word[8*i +: 8] = byp_data_q[8*i +: 8];
    end
  end
`else
  assign merged_word = bank_rdata;
`endif

  assign bus.RAMData = (ld_q.valid && !ld_q.mis) ? load_steer(ld_q.size, ld_q.lo, merged_word)
                                                 : 32'h0000_0000;

  logic        fault_q, fault_d;
  logic [31:0] faddr_q, faddr_d;

  // A new fault always wins over FaultClr; the store address wins over the load address.
  always_comb begin
    fault_d = fault_q;
    faddr_d = faddr_q;
    if (bus.FaultClr) fault_d = 1'b0;
    if (rd_mis || wr_mis) begin
      fault_d = 1'b1;
      if (!fault_q || bus.FaultClr) faddr_d = wr_mis ? bus.WADDR : bus.RADDR;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
      faddr_q <= '0;
    end else begin
      fault_q <= fault_d;
      faddr_q <= faddr_d;
    end
  end

  assign bus.Fault     = fault_q;
  assign bus.FaultAddr = faddr_q;

endmodule
